s_term_pipe: RTL and testbench

S_TERM_PIPE -- requirements
Module: s_term_pipe

---
 rtl/s_term_pipe.sv | 172 +++++++++++++++++
 tb/tb_s_term_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_term_pipe.sv
// s_term_pipe: south-terminal routing tile. Each wire group is forwarded
// north either directly, through a one- or two-cycle delay line, or blanked,
// as chosen by an 11-bit configuration word loaded from frame 0. Outputs are
// held at zero until the tile has received its first configuration word.
//
// Handshake: there is no valid/ready flow control. A configuration write is a
// single-cycle event: FrameStrobe[0]=1 and UserRST=0 at a UserCLK edge loads
// FrameData[10:0]. All other frame strobes are only passed through.

// One wire group: a free-running two-stage delay line plus a mode-selected tap.
module s_term_group #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [1:0]   mode,
    input  logic [W-1:0] src,
    output logic [W-1:0] dst
);

    logic [W-1:0] stage1;
    logic [W-1:0] stage2;

    // Delay line shifts every cycle in every mode so a mode change never
    // flushes or stalls the data already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            stage1 <= src;
            stage2 <= stage1;
        end
    end

    // Pick the tap named by the mode field; blank everything until configured.
    always_comb begin
        dst = '0;
        if (enable) begin
            case (mode)
                2'b00:   dst = src;
                2'b01:   dst = stage1;
                2'b10:   dst = stage2;
                default: dst = '0;
            endcase
        end
    end

endmodule

module s_term_pipe #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int W1              = 4,
    parameter int W2              = 8,
    parameter int W4              = 16
) (
    input  logic                       UserCLK,
    input  logic                       UserRST,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo,
    input  logic [W1-1:0]              S1END,
    input  logic [W2-1:0]              S2MID,
    input  logic [W2-1:0]              S2END,
    input  logic [W4-1:0]              S4END,
    input  logic [W4-1:0]              SS4END,
    output logic [W1-1:0]              N1BEG,
    output logic [W2-1:0]              N2BEG,
    output logic [W2-1:0]              N2BEGb,
    output logic [W4-1:0]              N4BEG,
    output logic [W4-1:0]              NN4BEG,
    output logic                       Co,
    output logic                       cfg_valid
);

    localparam int CfgBits = 11;

    // The configuration word occupies FrameData[10:0]; narrower frames
    // cannot carry it.
    generate
        if (FrameBitsPerRow < CfgBits) begin : g_frame_too_narrow
            $error("s_term_pipe: FrameBitsPerRow must be at least 11");
        end
    endgenerate

    // Frame data bits above the config word and strobes other than frame 0
    // carry nothing for this tile; fold them into a sink so they are
    // visibly intentional.
    generate
        if (FrameBitsPerRow > CfgBits) begin : g_spare_data
            logic unused_frame_data;
            assign unused_frame_data = ^FrameData[FrameBitsPerRow-1:CfgBits];
        end
        if (MaxFramesPerCol > 1) begin : g_spare_strobes
            logic unused_frame_strobes;
            assign unused_frame_strobes = ^FrameStrobe[MaxFramesPerCol-1:1];
        end
    endgenerate

    logic [CfgBits-1:0] cfg;
    logic               cfg_write;

    // Reset has priority over a frame write landing on the same edge.
    assign cfg_write = FrameStrobe[0] & ~UserRST;

    // Configuration word and its "loaded at least once" flag.
    always_ff @(posedge UserCLK) begin
        if (UserRST) begin
            cfg       <= '0;
            cfg_valid <= 1'b0;
        end else if (cfg_write) begin
            cfg       <= FrameData[CfgBits-1:0];
            cfg_valid <= 1'b1;
        end
    end

    // Clock and strobes are chained to the next tile untouched.
    assign FrameStrobe_O = FrameStrobe;
    assign UserCLKo      = UserCLK;

    // Carry seed comes straight from the top config bit once configured.
    assign Co = cfg_valid & cfg[10];

    s_term_group #(.W(W1)) u_grp_n1 (
        .clk    (UserCLK),
        .rst    (UserRST),
        .enable (cfg_valid),
        .mode   (cfg[1:0]),
        .src    (S1END),
        .dst    (N1BEG)
    );

    s_term_group #(.W(W2)) u_grp_n2 (
        .clk    (UserCLK),
        .rst    (UserRST),
        .enable (cfg_valid),
        .mode   (cfg[3:2]),
        .src    (S2MID),
        .dst    (N2BEG)
    );

    s_term_group #(.W(W2)) u_grp_n2b (
        .clk    (UserCLK),
        .rst    (UserRST),
        .enable (cfg_valid),
        .mode   (cfg[5:4]),
        .src    (S2END),
        .dst    (N2BEGb)
    );

    s_term_group #(.W(W4)) u_grp_n4 (
        .clk    (UserCLK),
        .rst    (UserRST),
        .enable (cfg_valid),
        .mode   (cfg[7:6]),
        .src    (S4END),
        .dst    (N4BEG)
    );

    s_term_group #(.W(W4)) u_grp_nn4 (
        .clk    (UserCLK),
        .rst    (UserRST),
        .enable (cfg_valid),
        .mode   (cfg[9:8]),
        .src    (SS4END),
        .dst    (NN4BEG)
    );

endmodule

// File: tb/tb_s_term_pipe.sv
// Bench for s_term_pipe: directed vector table, hand-written corner
// sequences (reset/write collision, mid-stream reset, pass-through during
// reset) and a randomized run checked against a history-queue model.
module tb_s_term_pipe;

    localparam int MF = 20;
    localparam int FB = 32;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          UserRST;
    logic [FB-1:0] FrameData;
    logic [MF-1:0] FrameStrobe;
    logic [MF-1:0] FrameStrobe_O;
    logic          UserCLKo;
    logic [3:0]    S1END;
    logic [7:0]    S2MID, S2END;
    logic [15:0]   S4END, SS4END;
    logic [3:0]    N1BEG;
    logic [7:0]    N2BEG, N2BEGb;
    logic [15:0]   N4BEG, NN4BEG;
    logic          Co, cfg_valid;

    always #5 clk = ~clk;

    s_term_pipe dut (
        .UserCLK       (clk),
        .UserRST       (UserRST),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .FrameStrobe_O (FrameStrobe_O),
        .UserCLKo      (UserCLKo),
        .S1END         (S1END),
        .S2MID         (S2MID),
        .S2END         (S2END),
        .S4END         (S4END),
        .SS4END        (SS4END),
        .N1BEG         (N1BEG),
        .N2BEG         (N2BEG),
        .N2BEGb        (N2BEGb),
        .N4BEG         (N4BEG),
        .NN4BEG        (NN4BEG),
        .Co            (Co),
        .cfg_valid     (cfg_valid)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic [MF-1:0] stb, input logic [FB-1:0] fd,
                         input logic [3:0] s1, input logic [7:0] s2m, input logic [7:0] s2e,
                         input logic [15:0] s4, input logic [15:0] ss4);
        UserRST     = rst;
        FrameStrobe = stb;
        FrameData   = fd;
        S1END       = s1;
        S2MID       = s2m;
        S2END       = s2e;
        S4END       = s4;
        SS4END      = ss4;
    endtask

    // Advance to just after the next active edge (inputs change at +1,
    // outputs are sampled at +2).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst;
        logic [MF-1:0] stb;
        logic [FB-1:0] fd;
        logic [3:0]    s1;
        logic [7:0]    s2m;
        logic [7:0]    s2e;
        logic [15:0]   s4;
        logic [15:0]   ss4;
        logic [3:0]    e_n1;
        logic [7:0]    e_n2;
        logic [7:0]    e_n2b;
        logic [15:0]   e_n4;
        logic [15:0]   e_nn4;
        logic          e_co;
        logic          e_valid;
    } vec_t;

    vec_t tbl[12];

    // ---------------- reference model ----------------
    // Each entry holds all five group inputs as sampled at one edge;
    // index 0 is the most recent sample, index 1 the one before it.
    typedef logic [4:0][15:0] grp_t;
    logic [10:0] m_cfg;
    logic        m_valid;
    grp_t        m_hist[$];

    function automatic grp_t sample_inputs();
        grp_t g;
        g    = '0;
        g[0] = 16'(S1END);
        g[1] = 16'(S2MID);
        g[2] = 16'(S2END);
        g[3] = S4END;
        g[4] = SS4END;
        return g;
    endfunction

    function automatic logic [15:0] m_out(input int g, input grp_t cur);
        logic [1:0] mode;
        mode = m_cfg[2*g +: 2];
        if (!m_valid) return 16'h0;
        case (mode)
            2'd0:    return cur[g];
            2'd1:    return m_hist[0][g];
            2'd2:    return m_hist[1][g];
            default: return 16'h0;
        endcase
    endfunction

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic m_edge();
        if (UserRST) begin
            m_cfg   = '0;
            m_valid = 1'b0;
            m_hist.delete();
            m_hist.push_back('0);
            m_hist.push_back('0);
        end else begin
            if (FrameStrobe[0]) begin
                m_cfg   = FrameData[10:0];
                m_valid = 1'b1;
            end
            m_hist.push_front(sample_inputs());
            void'(m_hist.pop_back());
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        grp_t cur;

        // cfg 0x790 = Co=1, NN4 blank, N4 2-delay, N2b 1-delay, N2/N1 direct
        tbl[0]  = '{1'b0, 20'h1,  32'h790, 4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 4'h0, 8'h00, 8'h00, 16'h0000, 16'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 20'h0,  32'h0,   4'hA, 8'h5C, 8'h3A, 16'h1234, 16'hFFFF, 4'hA, 8'h5C, 8'h00, 16'h0000, 16'h0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 20'h0,  32'h0,   4'h3, 8'hC5, 8'h7E, 16'hBEEF, 16'h0F0F, 4'h3, 8'hC5, 8'h3A, 16'h0000, 16'h0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 20'h0,  32'h0,   4'h6, 8'h01, 8'h80, 16'h0001, 16'h8000, 4'h6, 8'h01, 8'h7E, 16'h1234, 16'h0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 20'h0,  32'h0,   4'h0, 8'h00, 8'h00, 16'hA5A5, 16'h0000, 4'h0, 8'h00, 8'h80, 16'hBEEF, 16'h0, 1'b1, 1'b1};
        // rewrite N4 mode 10 -> 01 (cfg 0x750): next cycle shows 1-delay tap
        tbl[5]  = '{1'b0, 20'h1,  32'h750, 4'h9, 8'h42, 8'h24, 16'h5A5A, 16'h0001, 4'h9, 8'h42, 8'h00, 16'h0001, 16'h0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 20'h0,  32'h0,   4'h1, 8'h10, 8'h20, 16'h0F0F, 16'h0000, 4'h1, 8'h10, 8'h24, 16'h5A5A, 16'h0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 20'h0,  32'h0,   4'h2, 8'h00, 8'h00, 16'h0000, 16'h0000, 4'h2, 8'h00, 8'h20, 16'h0F0F, 16'h0, 1'b1, 1'b1};
        // frames 0 and 5 together, N1 mode -> 01 (cfg 0x751)
        tbl[8]  = '{1'b0, 20'h21, 32'h751, 4'h4, 8'h00, 8'h00, 16'h1111, 16'h0000, 4'h4, 8'h00, 8'h00, 16'h0000, 16'h0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 20'h0,  32'h0,   4'h7, 8'h00, 8'h00, 16'h0000, 16'h0000, 4'h4, 8'h00, 8'h00, 16'h1111, 16'h0, 1'b1, 1'b1};
        // frame 5 alone with all-zero data must not write
        tbl[10] = '{1'b0, 20'h20, 32'h0,   4'h8, 8'h00, 8'h00, 16'h0000, 16'h0000, 4'h7, 8'h00, 8'h00, 16'h0000, 16'h0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 20'h0,  32'h0,   4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 4'h8, 8'h00, 8'h00, 16'h0000, 16'h0, 1'b1, 1'b1};

        // Initial reset
        drive(1'b1, '0, '0, 4'h0, 8'h0, 8'h0, 16'h0, 16'h0);
        repeat (3) next_cycle();

        // Unconfigured tile stays dark for 10 cycles with S1END all ones
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, '0, 4'hF, 8'h0, 8'h0, 16'h0, 16'h0);
            #1;
            check("idle_n1", 32'(N1BEG), 32'h0);
            check("idle_co", 32'(Co), 32'h0);
            check("idle_valid", 32'(cfg_valid), 32'h0);
            next_cycle();
        end

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].stb, tbl[i].fd, tbl[i].s1, tbl[i].s2m,
                  tbl[i].s2e, tbl[i].s4, tbl[i].ss4);
            #1;
            check($sformatf("tbl%0d_n1", i),    32'(N1BEG),  32'(tbl[i].e_n1));
            check($sformatf("tbl%0d_n2", i),    32'(N2BEG),  32'(tbl[i].e_n2));
            check($sformatf("tbl%0d_n2b", i),   32'(N2BEGb), 32'(tbl[i].e_n2b));
            check($sformatf("tbl%0d_n4", i),    32'(N4BEG),  32'(tbl[i].e_n4));
            check($sformatf("tbl%0d_nn4", i),   32'(NN4BEG), 32'(tbl[i].e_nn4));
            check($sformatf("tbl%0d_co", i),    32'(Co),     32'(tbl[i].e_co));
            check($sformatf("tbl%0d_valid", i), 32'(cfg_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_stb_o", i), 32'(FrameStrobe_O), 32'(tbl[i].stb));
            next_cycle();
        end

        // Reset and frame write on the same edge, with data in flight: reset wins
        drive(1'b1, 20'h1, 32'h7FF, 4'hF, 8'hFF, 8'hFF, 16'hDEAD, 16'hFFFF);
        next_cycle();
        // Write all groups to 2-cycle delay (cfg 0x2AA); still dark this cycle
        drive(1'b0, 20'h1, 32'h2AA, 4'h5, 8'h55, 8'h55, 16'h1111, 16'h5555);
        #1;
        check("rstwr_valid", 32'(cfg_valid), 32'h0);
        check("rstwr_n1", 32'(N1BEG), 32'h0);
        check("rstwr_n4", 32'(N4BEG), 32'h0);
        check("rstwr_nn4", 32'(NN4BEG), 32'h0);
        check("rstwr_co", 32'(Co), 32'h0);
        next_cycle();
        drive(1'b0, 20'h0, 32'h0, 4'h6, 8'h66, 8'h66, 16'h2222, 16'h6666);
        #1;
        check("flush_valid", 32'(cfg_valid), 32'h1);
        check("flush_n4", 32'(N4BEG), 32'h0);
        check("flush_n1", 32'(N1BEG), 32'h0);
        check("flush_co", 32'(Co), 32'h0);
        next_cycle();
        #1;
        check("post_n4", 32'(N4BEG), 32'h1111);
        check("post_n1", 32'(N1BEG), 32'h5);
        check("post_nn4", 32'(NN4BEG), 32'h5555);

        // Pass-through of strobes and clock while held in reset
        UserRST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            FrameStrobe = MF'($urandom);
            #1;
            check("rst_stb_o_lo", 32'(FrameStrobe_O), 32'(FrameStrobe));
            check("rst_clko_lo", 32'(UserCLKo), 32'(clk));
            @(posedge clk);
            #1;
            FrameStrobe = MF'($urandom);
            #1;
            check("rst_stb_o_hi", 32'(FrameStrobe_O), 32'(FrameStrobe));
            check("rst_clko_hi", 32'(UserCLKo), 32'(clk));
        end
        check("rst_hold_valid", 32'(cfg_valid), 32'h0);

        // Randomized run against the reference model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            m_edge();
            #1;
            UserRST     = (c == 0) || ($urandom_range(0, 59) == 0);
            FrameStrobe = MF'($urandom);
            FrameStrobe[0] = ($urandom_range(0, 7) == 0);
            FrameData   = $urandom;
            S1END       = 4'($urandom);
            S2MID       = 8'($urandom);
            S2END       = 8'($urandom);
            S4END       = 16'($urandom);
            SS4END      = 16'($urandom);
            #1;
            if (c > 0) begin
                cur = sample_inputs();
                check("rnd_n1",  32'(N1BEG),  32'(m_out(0, cur)));
                check("rnd_n2",  32'(N2BEG),  32'(m_out(1, cur)));
                check("rnd_n2b", 32'(N2BEGb), 32'(m_out(2, cur)));
                check("rnd_n4",  32'(N4BEG),  32'(m_out(3, cur)));
                check("rnd_nn4", 32'(NN4BEG), 32'(m_out(4, cur)));
                check("rnd_co",  32'(Co),     32'(m_valid & m_cfg[10]));
                check("rnd_valid", 32'(cfg_valid), 32'(m_valid));
                check("rnd_stb_o", 32'(FrameStrobe_O), 32'(FrameStrobe));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
